// File: rtl/alu_sched.sv
// alu_sched: round-robin front end sharing one 32-bit alu between two requesters, with per-requester carry and wide multiply sequencing
module alu_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [7:0]  r0_op,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [7:0]  r1_op,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_c,
  output logic [31:0] rsp_hi,
  output logic [2:0]  rsp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [7:0]  alu_op,
  output logic        alu_carry_in,
  input  logic [31:0] alu_c,
  input  logic        alu_carry_out,
  input  logic        alu_is_zero,
  input  logic        alu_is_negative
);
  typedef enum logic [1:0] {IDLE, EXEC, EXEC_HI, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_last, r_wide;
  logic [1:0]  r_carry;
  logic        w_g0, w_g1, w_acc;
  logic [7:0]  w_op;
  logic [31:0] w_a, w_b;
  assign w_g0 = r0_valid & (~r1_valid | r_last);
  assign w_g1 = r1_valid & (~r0_valid | ~r_last);
  assign r0_ready = (r_state == IDLE) & w_g0;
  assign r1_ready = (r_state == IDLE) & w_g1;
  assign w_acc = r0_ready | r1_ready;
  assign w_op = w_g1 ? r1_op : r0_op;
  assign w_a = w_g1 ? r1_a : r0_a;
  assign w_b = w_g1 ? r1_b : r0_b;
  assign rsp_valid = r_state == RESP;
  assign alu_carry_in = r_carry[rsp_id];
  // next state: the wide multiply takes one extra alu pass for the high word
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE    ? (w_acc ? EXEC : IDLE) :
             r_state == EXEC    ? (r_wide ? EXEC_HI : RESP) :
             r_state == EXEC_HI ? RESP :
                                  (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  // operand latch on accept, result capture from the alu, per-requester carry
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_last    <= 1'b1;
      r_wide    <= 1'b0;
      r_carry   <= '0;
      rsp_id    <= 1'b0;
      rsp_c     <= '0;
      rsp_hi    <= '0;
      rsp_flags <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else begin
      if (w_acc) begin
        alu_a  <= w_a;
        alu_b  <= w_b;
        rsp_id <= w_g1;
        r_last <= w_g1;
        r_wide <= w_op[7];
        alu_op <= w_op[7] ? 8'd17 : {3'b0, w_op[4:0]};
      end
      if (r_state == EXEC) begin
        rsp_c <= alu_c;
        if (r_wide) alu_op <= 8'd18;
        else begin
          rsp_hi           <= '0;
          rsp_flags        <= {alu_carry_out, alu_is_negative, alu_is_zero};
          r_carry[rsp_id]  <= alu_carry_out;
        end
      end
      if (r_state == EXEC_HI) begin
        rsp_hi    <= alu_c;
        rsp_flags <= {1'b0, alu_c[31], (rsp_c == '0) && (alu_c == '0)};
      end
    end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a behavioural alu attached
module tb_alu_sched;
  logic        clk = 0, resetn = 0;
  logic        r0_valid = 0, r1_valid = 0, r0_ready, r1_ready;
  logic [7:0]  r0_op = 0, r1_op = 0;
  logic [31:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_id;
  logic [31:0] rsp_c, rsp_hi, alu_a, alu_b, alu_c;
  logic [2:0]  rsp_flags;
  logic [7:0]  alu_op;
  logic        alu_carry_in, alu_carry_out, alu_is_zero, alu_is_negative;
  logic [63:0] w_p;
  logic [32:0] w_s;

  typedef struct {logic id; logic [31:0] c; logic [31:0] hi; logic [2:0] f; int lat; int acc;} exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0, cyc = 0;
  int acc_cnt[2];
  logic [1:0] m_carry;
  logic m_last, seen, g;

  alu_sched dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_hi(rsp_hi), .rsp_flags(rsp_flags), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_carry_in(alu_carry_in), .alu_c(alu_c), .alu_carry_out(alu_carry_out),
    .alu_is_zero(alu_is_zero), .alu_is_negative(alu_is_negative)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign w_p = {32'b0, alu_a} * {32'b0, alu_b};
  assign w_s = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_op == 8'd1 && alu_carry_in};
  assign alu_c = alu_op <= 8'd1 ? w_s[31:0] : alu_op == 8'd17 ? w_p[31:0] : alu_op == 8'd18 ? w_p[63:32] : 32'd0;
  assign alu_carry_out = alu_op <= 8'd1 && w_s[32];
  assign alu_is_zero = alu_c == 0;
  assign alu_is_negative = alu_c[31];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic p, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t r;
    logic [63:0] pr;
    logic [32:0] s;
    r.id = p; r.lat = op[7] ? 3 : 2; r.acc = 0;
    if (op[7]) begin
      pr = {32'b0, a} * {32'b0, b};
      r.c = pr[31:0]; r.hi = pr[63:32]; r.f = {1'b0, pr[63], pr == 0};
    end else if (op[4:0] <= 5'd1) begin
      s = {1'b0, a} + {1'b0, b} + {32'b0, op[0] & cin};
      r.c = s[31:0]; r.hi = 0; r.f = {s[32], s[31], s[31:0] == 0};
    end else begin
      r.c = 0; r.hi = 0; r.f = 3'b001;
    end
    return r;
  endfunction

  // acceptance and response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!resetn) seen = 0;
    else begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("spurious_rsp", {63'b0, rsp_valid}, 64'd0);
        else begin
          if (!seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            seen = 1;
          end
          if (rsp_ready) begin
            e = q.pop_front();
            chk("rsp_id", {63'b0, rsp_id}, {63'b0, e.id});
            chk("rsp_c", {32'b0, rsp_c}, {32'b0, e.c});
            chk("rsp_hi", {32'b0, rsp_hi}, {32'b0, e.hi});
            chk("rsp_flags", {61'b0, rsp_flags}, {61'b0, e.f});
            seen = 0;
          end
        end
      end
      if (r0_ready || r1_ready) begin
        g = (r0_valid && r1_valid) ? ~m_last : r1_valid;
        chk("grant", {62'b0, r1_ready, r0_ready}, g ? 64'd2 : 64'd1);
        e = g ? model(1'b1, r1_op, r1_a, r1_b, m_carry[1]) : model(1'b0, r0_op, r0_a, r0_b, m_carry[0]);
        e.acc = cyc;
        q.push_back(e);
        m_last = g;
        if (!(g ? r1_op[7] : r0_op[7])) m_carry[g] = e.f[2];
        acc_cnt[g]++;
      end
    end
  end

  task automatic issue(input int p, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    if (p == 0) begin r0_valid = 1; r0_op = op; r0_a = a; r0_b = b; end
    else begin r1_valid = 1; r1_op = op; r1_a = a; r1_b = b; end
    do begin @(negedge clk); n++; end while (!(p == 0 ? r0_ready : r1_ready) && n < 60);
    if (n >= 60) chk("accept_timeout", {63'b0, p == 0 ? r0_ready : r1_ready}, 64'd1);
    @(posedge clk); #1;
    if (p == 0) r0_valid = 0; else r1_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 100) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_carry = 0;
    m_last = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1;
    model_reset();
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_c", {32'b0, rsp_c}, 64'd0);
    chk("rst_rsp_hi", {32'b0, rsp_hi}, 64'd0);
    chk("rst_flags_id", {60'b0, rsp_flags, rsp_id}, 64'd0);
    chk("rst_alu", {alu_a, 24'b0, alu_op}, 64'd0);
    chk("rst_carry_in", {63'b0, alu_carry_in}, 64'd0);
    @(posedge clk); #1 resetn = 1;
    // T1: carry producer then adc consuming it
    issue(0, 8'h00, 32'hFFFFFFFF, 32'd1);
    issue(0, 8'h01, 32'd0, 32'd0);
    drain();
    // T2: carry isolation between requesters
    issue(0, 8'h00, 32'hFFFFFFFF, 32'd1);
    issue(1, 8'h01, 32'd5, 32'd0);
    issue(0, 8'h01, 32'd5, 32'd0);
    // op[6:5] ignored, undefined code gives 0
    issue(0, 8'h60, 32'd3, 32'd4);
    issue(1, 8'h1F, 32'd1, 32'd1);
    drain();
    // T3: wide multiply, op[4:0] ignored
    issue(1, 8'h80, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(1, 8'h9F, 32'd0, 32'd1234);
    issue(0, 8'h80, 32'h12345678, 32'h9ABCDEF0);
    drain();
    // T4: both requesters valid continuously
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    r0_op = 8'h00; r0_a = 32'h10; r0_b = 32'h1; r1_op = 8'h01; r1_a = 32'h20; r1_b = 32'h2;
    r0_valid = 1; r1_valid = 1;
    repeat (24) @(posedge clk);
    #1 r0_valid = 0; r1_valid = 0;
    drain();
    chk("t4_r0_served", 64'(acc_cnt[0] - a0 >= 3), 64'd1);
    chk("t4_r1_served", 64'(acc_cnt[1] - a1 >= 3), 64'd1);
    // T5: response backpressure with a new command waiting
    rsp_ready = 0;
    issue(0, 8'h00, 32'd7, 32'd8);
    r1_valid = 1; r1_op = 8'h00; r1_a = 32'd9; r1_b = 32'd9;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid_held", {63'b0, rsp_valid}, 64'd1);
      chk("t5_c_held", {32'b0, rsp_c}, 64'd15);
      chk("t5_no_ready", {62'b0, r1_ready, r0_ready}, 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    issue(1, 8'h00, 32'd9, 32'd9);
    drain();
    // T6: reset in the middle of a wide multiply
    issue(0, 8'h00, 32'hFFFFFFFF, 32'd1);
    issue(1, 8'h00, 32'hFFFFFFFF, 32'd1);
    drain();
    issue(1, 8'h80, 32'd2, 32'd3);
    @(posedge clk); #1 resetn = 0;
    model_reset();
    @(negedge clk);
    chk("t6_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("t6_carry_in", {63'b0, alu_carry_in}, 64'd0);
    chk("t6_alu_op", {56'b0, alu_op}, 64'd0);
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    chk("t6_idle_valid", {63'b0, rsp_valid}, 64'd0);
    issue(0, 8'h01, 32'd0, 32'd0);
    issue(1, 8'h01, 32'd0, 32'd0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
